// File: rtl/timer_pkg.sv
// Shared types and helpers for the front-panel mode sequencer.
// Mode states, digit positions and the BCD increment used in set mode.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    SET_HR,
    SET_MIN
  } mode_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RUN,
    CMD_MODE,
    CMD_INC
  } cmd_e;

  localparam int DIG_SEC0 = 0;
  localparam int DIG_SEC1 = 1;
  localparam int DIG_MIN0 = 2;
  localparam int DIG_MIN1 = 3;
  localparam int DIG_HR0  = 4;
  localparam int DIG_HR1  = 5;

  localparam logic [5:0] BLANK_HR =
    (6'b1 << DIG_HR1) | (6'b1 << DIG_HR0);
  localparam logic [5:0] BLANK_MIN =
    (6'b1 << DIG_MIN1) | (6'b1 << DIG_MIN0);

  // Wrap check comes before the ones carry so 09->10 and max->00.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

endpackage

// File: rtl/timer_mode_ctrl_if.sv
// Command/status bundle between the mode sequencer and the timer
// datapath (timer_control plus the seven-segment mux blank mask).
interface timer_mode_ctrl_if;

  logic       run;
  logic       clr;
  logic       ld;
  logic [7:0] set_hr;
  logic [7:0] set_min;
  logic [7:0] cur_hr;
  logic [7:0] cur_min;
  logic [5:0] blank;

  modport master (
    output run, clr, ld,
    output set_hr, set_min, blank,
    input  cur_hr, cur_min
  );

  modport slave (
    input  run, clr, ld,
    input  set_hr, set_min, blank,
    output cur_hr, cur_min
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw button synchronizer and stable-count debouncer.
// Emits a one-cycle press pulse on each debounced rising level.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synced level differs from lvl_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        lvl_q   <= s2_q;
        press_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_mode_ctrl.sv
// Front-panel sequencer: debounced buttons drive the idle/run/pause
// and hour/minute set FSM, timer commands and the digit blink mask.
module timer_mode_ctrl
  import timer_pkg::*;
#(
  parameter int         DB_CYCLES = 1_000_000,
  parameter logic [7:0] HR_MAX    = 8'h23
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_run,
  input  logic btn_mode,
  input  logic btn_inc,
  input  logic blink_en,
  timer_mode_ctrl_if.master tif
);

  logic  p_run;
  logic  p_mode;
  logic  p_inc;
  cmd_e  cmd;

  mode_e      state_q, state_d;
  logic       run_q, run_d;
  logic       clr_q, clr_d;
  logic       ld_q, ld_d;
  logic [7:0] hr_q, hr_d;
  logic [7:0] min_q, min_d;
  logic       phase_q, phase_d;
  logic [5:0] blank_q, blank_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_run),
    .press_o (p_run)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_mode),
    .press_o (p_mode)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_inc),
    .press_o (p_inc)
  );

  // Coincident presses: run wins over mode, mode over inc.
  always_comb begin
    if (p_run)       cmd = CMD_RUN;
    else if (p_mode) cmd = CMD_MODE;
    else if (p_inc)  cmd = CMD_INC;
    else             cmd = CMD_NONE;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    clr_d   = 1'b0;
    ld_d    = 1'b0;
    hr_d    = hr_q;
    min_d   = min_q;
    phase_d = blink_en ? ~phase_q : phase_q;
    unique case (state_q)
      IDLE: begin
        case (cmd)
          CMD_RUN: begin
            state_d = RUN;
            run_d   = 1'b1;
          end
          CMD_MODE: begin
            state_d = SET_HR;
            hr_d    = tif.cur_hr;
            min_d   = tif.cur_min;
            phase_d = 1'b0;
          end
          default: ;
        endcase
      end
      RUN: begin
        if (cmd == CMD_RUN) begin
          state_d = PAUSE;
          run_d   = 1'b0;
        end
      end
      PAUSE: begin
        case (cmd)
          CMD_RUN: begin
            state_d = RUN;
            run_d   = 1'b1;
          end
          CMD_MODE: begin
            state_d = IDLE;
            clr_d   = 1'b1;
          end
          default: ;
        endcase
      end
      SET_HR: begin
        case (cmd)
          CMD_RUN:  state_d = IDLE;
          CMD_MODE: begin
            state_d = SET_MIN;
            phase_d = 1'b0;
          end
          CMD_INC:  hr_d = bcd_inc(hr_q, HR_MAX);
          default: ;
        endcase
      end
      SET_MIN: begin
        case (cmd)
          CMD_RUN:  state_d = IDLE;
          CMD_MODE: begin
            state_d = IDLE;
            ld_d    = 1'b1;
          end
          CMD_INC:  min_d = bcd_inc(min_q, 8'h59);
          default: ;
        endcase
      end
      default: begin
        state_d = IDLE;
        run_d   = 1'b0;
      end
    endcase
    blank_d = 6'b0;
    if (phase_d && state_d == SET_HR)  blank_d = BLANK_HR;
    if (phase_d && state_d == SET_MIN) blank_d = BLANK_MIN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      hr_q    <= 8'h00;
      min_q   <= 8'h00;
      phase_q <= 1'b0;
      blank_q <= 6'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      ld_q    <= ld_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end

  assign tif.run     = run_q;
  assign tif.clr     = clr_q;
  assign tif.ld      = ld_q;
  assign tif.set_hr  = hr_q;
  assign tif.set_min = min_q;
  assign tif.blank   = blank_q;

endmodule
